// File: rtl/muldiv_arbiter_if.sv
// muldiv_arbiter_if: hart request ports, shared mul/div unit port,
// and tagged writeback port of the mul/div arbiter.
interface muldiv_arbiter_if #(
   parameter int NUM_HARTS = 2,
   parameter int HART_W    = 1,
   parameter int XLEN      = 32,
   parameter int OP_W      = 3
);
   logic [NUM_HARTS-1:0]      req_valid;
   logic [NUM_HARTS-1:0]      req_ready;
   logic [NUM_HARTS*OP_W-1:0] req_op;
   logic [NUM_HARTS*XLEN-1:0] req_a;
   logic [NUM_HARTS*XLEN-1:0] req_b;
   logic [NUM_HARTS*5-1:0]    req_rd;
   logic [NUM_HARTS-1:0]      kill;
   logic                      md_start;
   logic [OP_W-1:0]           md_op;
   logic [XLEN-1:0]           md_a;
   logic [XLEN-1:0]           md_b;
   logic                      md_busy;
   logic                      md_done;
   logic [XLEN-1:0]           md_result;
   logic                      rsp_valid;
   logic [HART_W-1:0]         rsp_hart;
   logic [4:0]                rsp_rd;
   logic [XLEN-1:0]           rsp_result;
   logic                      arb_busy;

   modport slave (
      input  req_valid, req_op, req_a, req_b, req_rd, kill,
      input  md_busy, md_done, md_result,
      output req_ready, md_start, md_op, md_a, md_b,
      output rsp_valid, rsp_hart, rsp_rd, rsp_result, arb_busy
   );

   modport master (
      output req_valid, req_op, req_a, req_b, req_rd, kill,
      output md_busy, md_done, md_result,
      input  req_ready, md_start, md_op, md_a, md_b,
      input  rsp_valid, rsp_hart, rsp_rd, rsp_result, arb_busy
   );
endinterface

// File: rtl/muldiv_arbiter.sv
// muldiv_arbiter: round-robin sharing of one multi-cycle mul/div unit
// between harts, with flush-aware tagged writeback.
module muldiv_arbiter #(
   parameter int NUM_HARTS = 2,
   parameter int HART_W    = 1,
   parameter int XLEN      = 32,
   parameter int OP_W      = 3
) (
   input logic              clk,
   input logic              rst,
   muldiv_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [HART_W-1:0]     rr_ptr;
   logic [HART_W-1:0]     owner;
   logic [HART_W-1:0]     gnt;
   logic                  gnt_vld;
   logic                  killed;
   logic                  kill_own;
   logic                  accept;
   logic                  start;
   logic [NUM_HARTS-1:0]  ready;
   logic [NUM_HARTS-1:0]  elig;
   logic [OP_W-1:0]       op_q;
   logic [XLEN-1:0]       a_q;
   logic [XLEN-1:0]       b_q;
   logic [4:0]            rd_q;
   logic                  rsp_vld_q;
   logic [HART_W-1:0]     rsp_hart_q;
   logic [4:0]            rsp_rd_q;
   logic [XLEN-1:0]       rsp_res_q;

   assign elig     = bus.req_valid & ~bus.kill;
   assign kill_own = bus.kill[owner];

   // Pick the first eligible hart at or above rr_ptr, wrapping.
   always_comb begin
      logic [HART_W-1:0] idx;
      idx     = '0;
      gnt     = rr_ptr;
      gnt_vld = 1'b0;
      for (int i = NUM_HARTS - 1; i >= 0; i--) begin
         idx = rr_ptr + HART_W'(i);
         if (elig[idx]) begin
            gnt     = idx;
            gnt_vld = 1'b1;
         end
      end
   end

   // Next state, one-hot accept and the start pulse.
   always_comb begin
      state_nxt = state;
      ready     = '0;
      start     = 1'b0;
      accept    = 1'b0;
      unique case (state)
         IDLE: begin
            if (gnt_vld && !bus.md_busy) begin
               accept     = 1'b1;
               ready[gnt] = 1'b1;
               state_nxt  = ISSUE;
            end
         end
         ISSUE: begin
            start     = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (bus.md_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, operand latch, ownership and flush tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         rr_ptr <= '0;
         owner  <= '0;
         killed <= 1'b0;
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         rd_q   <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            owner  <= gnt;
            op_q   <= bus.req_op[int'(gnt)*OP_W +: OP_W];
            a_q    <= bus.req_a[int'(gnt)*XLEN +: XLEN];
            b_q    <= bus.req_b[int'(gnt)*XLEN +: XLEN];
            rd_q   <= bus.req_rd[int'(gnt)*5 +: 5];
            killed <= 1'b0;
         end else if (state != IDLE && kill_own) begin
            killed <= 1'b1;
         end
         if (state == WAIT && bus.md_done)
            rr_ptr <= owner + 1'b1;
      end
   end

   // Tagged writeback; a flush seen with md_done still drops it.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_vld_q  <= 1'b0;
         rsp_hart_q <= '0;
         rsp_rd_q   <= '0;
         rsp_res_q  <= '0;
      end else begin
         rsp_vld_q <= 1'b0;
         if (state == WAIT && bus.md_done && !killed && !kill_own) begin
            rsp_vld_q  <= 1'b1;
            rsp_hart_q <= owner;
            rsp_rd_q   <= rd_q;
            rsp_res_q  <= bus.md_result;
         end
      end
   end

   assign bus.req_ready  = ready;
   assign bus.md_start   = start;
   assign bus.md_op      = op_q;
   assign bus.md_a       = a_q;
   assign bus.md_b       = b_q;
   assign bus.rsp_valid  = rsp_vld_q;
   assign bus.rsp_hart   = rsp_hart_q;
   assign bus.rsp_rd     = rsp_rd_q;
   assign bus.rsp_result = rsp_res_q;
   assign bus.arb_busy   = (state != IDLE);
endmodule

// File: tb/tb_muldiv_arbiter.sv
// tb_muldiv_arbiter: directed and random stimulus against a
// transaction-level reference model of the arbiter.
module tb_muldiv_arbiter;
   localparam int N = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   muldiv_arbiter_if #(.NUM_HARTS(N), .HART_W(1), .XLEN(32), .OP_W(3)) bus ();

   muldiv_arbiter #(.NUM_HARTS(N), .HART_W(1), .XLEN(32), .OP_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // stimulus shadows applied at each falling edge
   logic         s_rst;
   logic [N-1:0] s_valid, s_kill, p_auto;
   logic [2:0]   p_op [N];
   logic [31:0]  p_a [N], p_b [N];
   logic [4:0]   p_rd [N];
   logic         f_busy;
   int           u_lat;

   // unit model
   int           u_cnt;
   logic [31:0]  u_res;

   // reference model
   bit           m_infl, m_start, m_killed, m_rsp, m_fresh;
   int           m_owner, m_rr;
   logic [2:0]   m_op;
   logic [31:0]  m_a, m_b;
   logic [4:0]   m_rd;
   int           e_hart;
   logic [4:0]   e_rd;
   logic [31:0]  e_res;

   int n_chk, n_err;
   int cyc, last_acc, acc_cnt, n_supp;
   int start_cyc, rsp_cyc;
   int resp_cnt [N];
   logic [31:0] o_res;
   logic [4:0]  o_rd;
   int          o_hart;

   function automatic logic [31:0] ref_res(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      if (op < 3'd4) return a * b;
      if (b == 32'd0) return 32'hffff_ffff;
      return a / b;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic rand_req(input int h);
      p_op[h] = 3'($urandom_range(0, 7));
      p_a[h]  = $urandom_range(0, 100000);
      p_b[h]  = $urandom_range(0, 300);
      p_rd[h] = 5'($urandom_range(1, 31));
   endtask

   task automatic step();
      logic [N-1:0] elig, exp_rdy;
      bit found;
      @(negedge clk);
      cyc++;
      bus.md_done = 1'b0;
      bus.md_result = $urandom;
      if (u_cnt > 0) begin
         u_cnt--;
         if (u_cnt == 0) begin
            bus.md_done   = 1'b1;
            bus.md_result = u_res;
         end
      end
      bus.md_busy   = (u_cnt > 0) || f_busy;
      rst           = s_rst;
      bus.req_valid = s_valid;
      bus.kill      = s_kill;
      for (int h = 0; h < N; h++) begin
         bus.req_op[h*3 +: 3]  = p_op[h];
         bus.req_a[h*32 +: 32] = p_a[h];
         bus.req_b[h*32 +: 32] = p_b[h];
         bus.req_rd[h*5 +: 5]  = p_rd[h];
      end
      #1;
      last_acc = -1;
      if (rst) begin
         m_infl = 0; m_start = 0; m_killed = 0; m_rsp = 0;
         m_rr = 0; m_fresh = 1; m_op = '0; m_a = '0; m_b = '0;
      end else begin
         elig = s_valid & ~s_kill;
         exp_rdy = '0;
         found = 0;
         if (!m_infl && !bus.md_busy) begin
            for (int i = 0; i < N; i++) begin
               if (!found && elig[(m_rr + i) % N]) begin
                  exp_rdy[(m_rr + i) % N] = 1'b1;
                  found = 1;
               end
            end
         end
         chk("req_ready", bus.req_ready, exp_rdy);
         chk("md_start", bus.md_start, m_start);
         chk("arb_busy", bus.arb_busy, m_infl);
         if (m_infl || m_fresh) begin
            chk("md_op", bus.md_op, m_op);
            chk("md_a", bus.md_a, m_a);
            chk("md_b", bus.md_b, m_b);
         end
         chk("rsp_valid", bus.rsp_valid, m_rsp);
         if (m_rsp && bus.rsp_valid) begin
            chk("rsp_hart", bus.rsp_hart, e_hart);
            chk("rsp_rd", bus.rsp_rd, e_rd);
            chk("rsp_result", bus.rsp_result, e_res);
            resp_cnt[bus.rsp_hart]++;
            rsp_cyc = cyc;
            o_res = bus.rsp_result;
            o_rd = bus.rsp_rd;
            o_hart = int'(bus.rsp_hart);
         end
         if (m_start) start_cyc = cyc;
         m_rsp = 0;
         if (m_infl) begin
            if (!m_start && bus.md_done) begin
               if (!m_killed && !s_kill[m_owner]) begin
                  m_rsp = 1;
                  e_hart = m_owner;
                  e_rd = m_rd;
                  e_res = ref_res(m_op, m_a, m_b);
               end else begin
                  n_supp++;
               end
               m_rr = (m_owner + 1) % N;
               m_infl = 0;
            end else if (s_kill[m_owner]) begin
               m_killed = 1;
            end
         end
         m_start = 0;
         for (int h = 0; h < N; h++) begin
            if (exp_rdy[h]) begin
               m_infl = 1; m_start = 1; m_killed = 0; m_fresh = 0;
               m_owner = h;
               m_op = p_op[h]; m_a = p_a[h]; m_b = p_b[h]; m_rd = p_rd[h];
               last_acc = h;
               acc_cnt++;
            end
         end
      end
      if (bus.md_start && !rst) begin
         u_cnt = u_lat;
         u_res = ref_res(bus.md_op, bus.md_a, bus.md_b);
      end
      if (last_acc >= 0 && p_auto[last_acc]) rand_req(last_acc);
   endtask

   task automatic do_reset();
      s_rst = 1'b1;
      step();
      step();
      s_rst = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((m_infl || m_rsp) && k < 200) begin
         step();
         k++;
      end
      chk("drain_timeout", 64'(m_infl | m_rsp), 0);
   endtask

   task automatic wait_acc(input string tag);
      int k;
      k = 0;
      step();
      while (last_acc < 0 && k < 200) begin
         step();
         k++;
      end
      chk(tag, 64'(last_acc >= 0), 1);
   endtask

   initial begin
      int exp_alt, r0, r1, s0;
      n_chk = 0; n_err = 0; cyc = 0; acc_cnt = 0; n_supp = 0;
      u_cnt = 0; u_lat = 4; f_busy = 0; p_auto = '0;
      s_rst = 1'b1; s_valid = '0; s_kill = '0;
      for (int h = 0; h < N; h++) begin
         resp_cnt[h] = 0;
         rand_req(h);
      end
      rst = 1'b1;
      bus.md_done = 1'b0; bus.md_busy = 1'b0; bus.md_result = '0;
      bus.req_valid = '0; bus.kill = '0;
      bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.req_rd = '0;

      step(); step(); step();
      s_rst = 1'b0;
      step();
      chk("rst_rsp_hart", bus.rsp_hart, 0);
      chk("rst_rsp_rd", bus.rsp_rd, 0);
      chk("rst_rsp_result", bus.rsp_result, 0);
      chk("rst_md_a", bus.md_a, 0);

      // single request, latency 4
      p_op[0] = 3'd0; p_a[0] = 32'd10; p_b[0] = 32'd3; p_rd[0] = 5'd3;
      s_valid = 2'b01; u_lat = 4;
      wait_acc("t1_accept");
      chk("t1_grant", last_acc, 0);
      s_valid = '0;
      drain();
      chk("t1_nrsp", resp_cnt[0], 1);
      chk("t1_result", o_res, 30);
      chk("t1_rd", o_rd, 3);
      chk("t1_hart", o_hart, 0);
      chk("t1_latency", rsp_cyc - start_cyc, 5);

      // contention from reset
      do_reset();
      resp_cnt[0] = 0; resp_cnt[1] = 0;
      p_auto = 2'b11; rand_req(0); rand_req(1);
      s_valid = 2'b11;
      acc_cnt = 0; exp_alt = 0;
      for (int k = 0; k < 400 && acc_cnt < 8; k++) begin
         u_lat = $urandom_range(1, 5);
         step();
         if (last_acc >= 0) begin
            chk("t2_alternate", last_acc, exp_alt);
            exp_alt = 1 - exp_alt;
         end
      end
      chk("t2_ops", acc_cnt, 8);
      s_valid = '0;
      drain();
      chk("t2_rsp_h0", resp_cnt[0], 4);
      chk("t2_rsp_h1", resp_cnt[1], 4);

      // kill the owner during WAIT
      p_auto = '0;
      p_op[1] = 3'd4; p_a[1] = 32'd10; p_b[1] = 32'd3; p_rd[1] = 5'd4;
      s_valid = 2'b10; u_lat = 5;
      r1 = resp_cnt[1]; s0 = n_supp;
      wait_acc("t3_accept");
      chk("t3_grant", last_acc, 1);
      s_valid = '0;
      step(); step();
      s_kill = 2'b10;
      step();
      s_kill = '0;
      rand_req(0);
      s_valid = 2'b11;
      wait_acc("t3_next_accept");
      chk("t3_next_grant", last_acc, 0);
      chk("t3_suppressed", n_supp - s0, 1);
      chk("t3_no_rsp_h1", resp_cnt[1], r1);
      s_valid = '0;
      drain();

      // killed hart skipped at arbitration
      do_reset();
      s_valid = 2'b11; s_kill = 2'b01;
      step();
      chk("t4_ready", bus.req_ready, 2'b10);
      s_valid = '0; s_kill = '0;
      drain();

      // unit busy blocks grant
      f_busy = 1'b1; rand_req(0); s_valid = 2'b01;
      for (int k = 0; k < 10; k++) begin
         step();
         chk("t5_no_ready", bus.req_ready, 0);
         chk("t5_no_start", bus.md_start, 0);
      end
      f_busy = 1'b0;
      step();
      chk("t5_grant", last_acc, 0);
      s_valid = '0;
      drain();

      // reset during WAIT, late md_done ignored
      rand_req(1); s_valid = 2'b10; u_lat = 6;
      wait_acc("t6_accept");
      s_valid = '0;
      step(); step(); step();
      r0 = resp_cnt[0] + resp_cnt[1];
      s_rst = 1'b1;
      step();
      s_rst = 1'b0;
      step();
      chk("t6_arb_busy", bus.arb_busy, 0);
      chk("t6_md_op", bus.md_op, 0);
      chk("t6_md_a", bus.md_a, 0);
      chk("t6_md_b", bus.md_b, 0);
      chk("t6_rsp_hart", bus.rsp_hart, 0);
      chk("t6_rsp_rd", bus.rsp_rd, 0);
      chk("t6_rsp_result", bus.rsp_result, 0);
      for (int k = 0; k < 20 && u_cnt > 0; k++) step();
      step(); step();
      chk("t6_no_rsp", resp_cnt[0] + resp_cnt[1], r0);
      rand_req(0); rand_req(1); s_valid = 2'b11; u_lat = 3;
      wait_acc("t6_fresh_accept");
      chk("t6_fresh_grant", last_acc, 0);
      s_valid = '0;
      drain();
      chk("t6_fresh_rsp", resp_cnt[0] + resp_cnt[1], r0 + 1);

      // random traffic with flushes and busy stalls
      p_auto = 2'b11;
      for (int k = 0; k < 2000; k++) begin
         s_valid = 2'($urandom_range(0, 3));
         s_kill[0] = ($urandom_range(0, 15) == 0);
         s_kill[1] = ($urandom_range(0, 15) == 0);
         f_busy = ($urandom_range(0, 9) == 0);
         u_lat = $urandom_range(1, 6);
         step();
      end
      s_valid = '0; s_kill = '0; f_busy = 1'b0;
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/muldiv_arbiter.md
# muldiv_arbiter

Round-robin controller that shares the single multi-cycle mul/div unit between the CPU harts. Accepts at most one M-extension operation at a time from per-hart request ports and drives the unit's start/operand interface. It returns the result tagged with hart id and destination register, and discards results of operations whose hart was flushed. Sits in the CPU between the hart execute stages and the shared mul/div datapath.

## Interface
- NUM_HARTS, 2, number of requesting harts (power of two, ≥2)
- HART_W, 1, log2(NUM_HARTS)
- XLEN, 32, operand/result width
- OP_W, 3, mul/div opcode width (funct3 encoding, passed through unopened)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_HARTS  per-hart request
- req_op  in  NUM_HARTS*OP_W  per-hart opcode, hart h at bits [h*OP_W +: OP_W]
- req_a, req_b  in  NUM_HARTS*XLEN  per-hart operands, same packing
- req_rd  in  NUM_HARTS*5  per-hart destination register
- req_ready  out  NUM_HARTS  one-hot accept; request consumed on cycle where valid & ready
- kill  in  NUM_HARTS  per-hart flush; cancels that hart's pending/in-flight op
- md_start  out  1  one-cycle start pulse to unit
- md_op  out  OP_W  latched opcode
- md_a, md_b  out  XLEN  latched operands
- md_busy  in  1  unit busy
- md_done  in  1  one-cycle completion pulse
- md_result  in  XLEN  valid with md_done
- rsp_valid  out  1  one-cycle writeback pulse
- rsp_hart  out  HART_W  owner of result
- rsp_rd  out  5  destination register
- rsp_result  out  XLEN  result
- arb_busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: eligible = req_valid & ~kill. If eligible≠0 and md_busy=0: grant first eligible hart searching from rr_ptr upward (mod NUM_HARTS); req_ready[grant]=1 combinationally (all other bits 0); latch op/a/b/rd/hart; clear killed flag; → ISSUE. Otherwise req_ready=0, stay.
- ISSUE: md_start=1 for exactly this cycle with latched md_op/md_a/md_b; → WAIT.
- WAIT: hold md_op/md_a/md_b stable. On md_done: if killed=0, register rsp_valid=1 with rsp_hart/rsp_rd/rsp_result=md_result for the next cycle; rr_ptr ← (owner+1) mod NUM_HARTS; → IDLE.
- kill[owner] asserted in ISSUE or WAIT sets killed; the unit is not aborted. The arbiter still waits for md_done, then suppresses rsp_valid. rr_ptr still advances.
- kill on a non-owner hart outside IDLE: no effect on the in-flight op.
- md_done in IDLE or ISSUE: ignored. No response is generated and no state changes.
- Arbiter never reorders: one op in flight, response precedes next grant's response.

## Timing
- Reset values: state=IDLE, rr_ptr=0, killed=0, req_ready=0, md_start=0, md_op/md_a/md_b=0, rsp_valid=0, rsp_hart=0, rsp_rd=0, rsp_result=0, arb_busy=0.
- Accept at cycle T (valid&ready) → md_start at T+1 → md_done at T+1+L (L = unit latency ≥1) → rsp_valid at T+2+L.
- Next grant possible in the cycle after md_done (state IDLE). That grant can coincide with the previous op's rsp_valid.
- rsp_valid, md_start: single-cycle pulses, never back-to-back from one op.
- Reset mid-operation returns to IDLE immediately with reset values. A subsequent md_done from the unit is ignored.
- Simultaneous kill and md_done in WAIT: kill wins, response suppressed.

## Test plan
- Single request: hart0 mul a=10 b=3 rd=3, unit L=4 returns 30 → md_start 1 cycle after accept; rsp_valid once, rsp_hart=0, rsp_rd=3, rsp_result=30, 5 cycles after md_start.
- Contention: both harts request every cycle from reset, 8 ops total → grants alternate 0,1,0,1…; each hart receives 4 responses with correct rd/result; never two ops in flight.
- Kill in flight: hart1 div 10/3 rd=4 granted, kill[1] pulsed during WAIT → md_done observed, no rsp_valid. The next grant goes to hart0 if it is requesting.
- Kill vs arbitration: in IDLE, req_valid=2'b11 and kill=2'b01 with rr_ptr=0 → hart1 granted, req_ready=2'b10.
- md_busy held high for 10 cycles with pending request → req_ready stays 0, no md_start. Grant occurs in the first cycle md_busy=0.
- Reset during WAIT, then md_done pulse → all outputs at reset values, no rsp_valid. A fresh request afterwards completes normally with rr_ptr=0.
